// File: rtl/mesh_torus_lkahead_route_pipe.sv
// Look-ahead XY route stage for one NoC input port: computes the next router's exit port
// for header flits and replays it per VC for body/tail flits, through a PIPE-deep register pipe.
module mesh_torus_lkahead_route_pipe #(
  parameter string TOPOLOGY = "MESH",
  parameter int    NX       = 4,
  parameter int    NY       = 4,
  parameter int    V        = 4,
  parameter int    PIPE     = 1,
  localparam int   Xw       = (NX > 1) ? $clog2(NX) : 1,
  localparam int   Yw       = (NY > 1) ? $clog2(NY) : 1,
  localparam int   Vw       = (V  > 1) ? $clog2(V)  : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [Xw-1:0] current_x,
  input  logic [Yw-1:0] current_y,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Vw-1:0] in_vc,
  input  logic          in_hdr,
  input  logic          in_tail,
  input  logic [Xw-1:0] in_dest_x,
  input  logic [Yw-1:0] in_dest_y,
  input  logic [4:0]    in_destport,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Vw-1:0] out_vc,
  output logic          out_hdr,
  output logic          out_tail,
  output logic [4:0]    out_lkdestport,
  output logic [V-1:0]  vc_busy,
  output logic          err
);

  localparam bit         IS_TORUS = (TOPOLOGY == "TORUS");
  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_E = 5'b00010;
  localparam logic [4:0] P_N = 5'b00100;
  localparam logic [4:0] P_W = 5'b01000;
  localparam logic [4:0] P_S = 5'b10000;
  localparam int         DW  = Vw + 7;

  // Handshake: a flit moves on a cycle where valid and ready are both high; a producer holds
  // valid and its payload stable until it is taken, and ready never depends on valid.

  int         nxi, nyi, dxi, dyi, fx, fy;
  logic [4:0] hdr_port;
  logic [4:0] lk_port;
  logic [4:0] tbl [V];
  logic [V-1:0] busy;
  logic       err_q;

  logic [PIPE-1:0] st_v;
  logic [PIPE-1:0] st_load;
  logic [DW-1:0]   st_d [PIPE];
  logic            accept;

  // Next-router coordinate, then XY decision evaluated there.
  always_comb begin
    nxi = int'(current_x);
    nyi = int'(current_y);
    dxi = int'(in_dest_x);
    dyi = int'(in_dest_y);
    case (in_destport)
      P_E:     nxi = nxi + 1;
      P_W:     nxi = nxi - 1;
      P_N:     nyi = nyi - 1;
      P_S:     nyi = nyi + 1;
      default: ;
    endcase
    if (IS_TORUS) begin
      if (nxi >= NX)   nxi = 0;
      else if (nxi < 0) nxi = NX - 1;
      if (nyi >= NY)   nyi = 0;
      else if (nyi < 0) nyi = NY - 1;
    end
    // Forward distance; operands are non-negative so % is a true modulo here.
    fx = (dxi - nxi + NX) % NX;
    fy = (dyi - nyi + NY) % NY;
    hdr_port = P_L;
    if (in_destport == P_L) begin
      hdr_port = P_L;
    end else if (dxi != nxi) begin
      if (IS_TORUS) hdr_port = (fx <= NX / 2) ? P_E : P_W;
      else          hdr_port = (dxi > nxi)    ? P_E : P_W;
    end else if (dyi != nyi) begin
      if (IS_TORUS) hdr_port = (fy <= NY / 2) ? P_S : P_N;
      else          hdr_port = (dyi > nyi)    ? P_S : P_N;
    end
  end

  // Body/tail on an idle VC carries no route.
  always_comb begin
    if (in_hdr)            lk_port = hdr_port;
    else if (busy[in_vc])  lk_port = tbl[in_vc];
    else                   lk_port = '0;
  end

  // Stage i may load when empty or when its occupant leaves this cycle.
  always_comb begin
    logic r;
    r       = out_ready;
    st_load = '0;
    for (int i = PIPE - 1; i >= 0; i--) begin
      st_load[i] = !st_v[i] || r;
      r          = st_load[i];
    end
  end

  assign in_ready = !reset && st_load[0];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_v <= '0;
      for (int i = 0; i < PIPE; i++) st_d[i] <= '0;
    end else begin
      if (st_load[0]) begin
        st_v[0] <= accept;
        if (accept) st_d[0] <= {in_vc, in_hdr, in_tail, lk_port};
      end
      for (int i = 1; i < PIPE; i++) begin
        if (st_load[i]) begin
          st_v[i] <= st_v[i-1];
          if (st_v[i-1]) st_d[i] <= st_d[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < V; i++) tbl[i] <= '0;
    end else if (accept) begin
      if (in_hdr) begin
        tbl[in_vc]  <= hdr_port;
        busy[in_vc] <= !in_tail;
        if (busy[in_vc]) err_q <= 1'b1;
      end else begin
        if (!busy[in_vc]) err_q <= 1'b1;
        if (in_tail) busy[in_vc] <= 1'b0;
      end
    end
  end

  assign out_valid = st_v[PIPE-1];
  assign {out_vc, out_hdr, out_tail, out_lkdestport} = st_d[PIPE-1];
  assign vc_busy   = busy;
  assign err       = err_q;

endmodule

// File: doc/mesh_torus_lkahead_route_pipe.md
# mesh_torus_lkahead_route_pipe

Pipelined, multi-VC look-ahead route computation stage for one router input port in the MESH/TORUS NoC. It uses a valid/ready handshake, and the pipeline depth is a parameter. Header flits carry a destination and the port they will leave through at this router. From these the block computes the output port the flit will need at the next router (XY order, with shortest-path wrap in TORUS). Per virtual channel, it latches that look-ahead port so body and tail flits of the same packet get it without recomputation. It sits between the input-port flit buffer and the VC/switch allocator.

## Interface
Parameters:
- TOPOLOGY, "MESH": "MESH" or "TORUS"; any other value is illegal.
- NX, 4: routers in x; must be ≥2.
- NY, 4: routers in y; must be ≥2.
- V, 4: virtual channels per port; must be ≥1.
- PIPE, 1: register stages between input and output; 1 or 2.
- Derived widths:
  - Xw = log2(NX), Yw = log2(NY), Vw = log2(V).
  - log2(n) = max(1, ceil(log2 n)).
- Port encoding is one-hot, 5 bits: bit0 LOCAL, bit1 EAST (x+1), bit2 NORTH (y−1), bit3 WEST (x−1), bit4 SOUTH (y+1).

Ports:
- clk, in, 1: clock; the only clock.
- reset, in, 1: synchronous, active-high reset.
- current_x, in, Xw: this router's x; static.
- current_y, in, Yw: this router's y; static.
- in_valid, in, 1: input flit valid.
- in_ready, out, 1: block can accept a flit this cycle.
- in_vc, in, Vw: VC number of the input flit.
- in_hdr, in, 1: flit is a header.
- in_tail, in, 1: flit is a tail (hdr and tail both set = single-flit packet).
- in_dest_x, in, Xw: destination x; used only on headers.
- in_dest_y, in, Yw: destination y; used only on headers.
- in_destport, in, 5: one-hot exit port at this router; used only on headers.
- out_valid, out, 1: output flit valid.
- out_ready, in, 1: downstream accepts the output flit.
- out_vc, out, Vw: VC of the output flit.
- out_hdr, out, 1: header flag of the output flit.
- out_tail, out, 1: tail flag of the output flit.
- out_lkdestport, out, 5: one-hot port to use at the next router.
- vc_busy, out, V: per-VC flag, set while that VC holds a latched route.
- err, out, 1: sticky protocol error flag.

## Operation
- A transfer happens on a cycle where in_valid and in_ready are both high.
- Next-router coordinate (nx, ny) is current_x/current_y stepped one hop in the in_destport direction:
  - MESH: plain step; no bounds wrap.
  - TORUS: x wraps modulo NX, y wraps modulo NY.
  - in_destport = LOCAL: look-ahead result is LOCAL.
- XY route evaluated at (nx, ny):
  - nx ≠ dest_x: resolve x first. MESH picks EAST if dest_x > nx, else WEST.
  - nx = dest_x and ny ≠ dest_y: resolve y. MESH picks SOUTH if dest_y > ny, else NORTH.
  - Both equal: LOCAL.
- TORUS direction choice:
  - Forward distance d = (dest − n) mod N.
  - EAST/SOUTH if d ≤ N/2 (integer division), else WEST/NORTH. A tie goes to the positive direction.
- Per-VC route table: V entries, each 5 bits plus a busy bit.
  - Accepted header: computed port is written to entry in_vc and busy is set.
  - Accepted non-header: its look-ahead port is read from entry in_vc.
  - Accepted tail: clears busy in the same write.
  - Header with tail: writes the port but leaves busy clear.
- Error cases; each sets err, and err stays set until reset:
  - Non-header arrives on a non-busy VC. The flit is still forwarded with out_lkdestport = 0.
  - Header arrives on a busy VC. The new route overwrites the old one.
- in_destport not one-hot: behaviour undefined; the bench does not drive it.

## Timing
- Reset takes effect on a clk edge with reset high. While reset is high and on the first cycle after:
  - out_valid = 0, vc_busy = 0, err = 0.
  - out_vc, out_hdr, out_tail, out_lkdestport = 0.
  - in_ready = 0.
  - All table entries = 0.
- Reset mid-packet drops all in-flight flits and busy state.
- Latency: exactly PIPE cycles from the accept edge to out_valid, when there is no backpressure.
- Throughput: one flit per cycle.
- Each stage is a register with a valid bit. A stage loads when it is empty or when its contents move on in the same cycle.
- in_ready = !reset && (stage1 empty || stage1 advancing). The only combinational path from output to input is out_ready → in_ready; there is no combinational path from in_valid to any output.
- While out_valid is high and out_ready is low, all output signals hold stable.
- Table write happens at the accept edge, and the table read is combinational at the input. Consequences:
  - A header on VC k followed in the next cycle by a body on VC k gets the new route.
  - A tail followed in the next cycle by a header on the same VC is legal.
- Flits leave in the same order they arrived, including across VCs.

## Test plan
- MESH, NX=NY=4, current (1,1). Header VC0 with dest (3,2) and destport EAST → after PIPE cycles, out_lkdestport=EAST (next router (2,1)). Then body and tail on VC0 → both EAST. vc_busy[0] goes 1 at the header and 0 after the tail.
- MESH, same current (1,1). Header dest (2,1), destport EAST → LOCAL. Header dest (1,3), destport SOUTH → SOUTH. Header with destport LOCAL → LOCAL.
- TORUS, NX=NY=4, current (3,0):
  - Header dest (0,0), destport EAST → wraps to (0,0) → LOCAL.
  - Header dest (2,0), destport EAST → next (0,0); d=2 ≤ 2 → EAST.
  - Header dest (3,0), destport EAST → d=3 → WEST.
- Interleave V=4: headers on VC0 (EAST) and VC2 (NORTH), then alternate body flits on VC2 and VC0. Each flit carries its own VC's route and output order matches input order.
- Backpressure with PIPE=2: hold out_ready=0 for 5 cycles while streaming → in_ready falls after 2 accepts and outputs stay stable. Release → flits drain in order with no loss or duplication.
- Errors and reset:
  - Body flit on idle VC1 → err=1 and out_lkdestport=0.
  - Assert reset mid-packet → all outputs 0, err=0, vc_busy=0 next cycle.
